// File: rtl/pipelined_ripple_adder.sv
// Segmented ripple-carry adder/subtractor, pipelined one SEG-bit segment per stage.
// Stage k adds operand segment k plus the carry registered by stage k-1. Upper operand
// segments travel alongside in skew registers, and finished lower result segments travel
// in de-skew registers, so every bit of one operation leaves the pipe on the same cycle.
// The last stage's registers are the output registers.
module pipelined_ripple_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / SEG;
  localparam int unsigned LAST   = STAGES - 1;

  // Whole pipe advances together; it only holds when a result is waiting downstream.
  logic en;

  // Subtraction is A + ~B + 1, so the inversion and the forced carry-in happen up front.
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Inputs seen by each stage's adder (stage 0 from the ports, stage k from stage k-1).
  logic [STAGES-1:0][WIDTH-1:0] stg_a;
  logic [STAGES-1:0][WIDTH-1:0] stg_b;
  logic [STAGES-1:0][WIDTH-1:0] stg_s;
  logic [STAGES-1:0]            stg_c;
  logic [STAGES-1:0]            stg_v;

  // Registered state of each stage.
  logic [STAGES-1:0][WIDTH-1:0] a_r;
  logic [STAGES-1:0][WIDTH-1:0] b_r;
  logic [STAGES-1:0][WIDTH-1:0] s_r;
  logic [STAGES-1:0]            c_r;
  logic [STAGES-1:0]            v_r;

  // Per-stage segment result: {carry out, SEG sum bits}.
  logic [STAGES-1:0][SEG:0]     seg_res;

  logic msb_carry;
  logic ovf_q;

  assign en       = !v_r[LAST] || out_ready;
  assign in_ready = en && !rst;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub | cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * SEG;

    logic [WIDTH-1:0] s_next;
    logic [WIDTH-1:0] s_q;
    logic             c_q;
    logic             v_q;

    if (k == 0) begin : g_head
      assign stg_a[k] = a;
      assign stg_b[k] = b_eff;
      assign stg_s[k] = '0;
      assign stg_c[k] = c0;
      assign stg_v[k] = in_valid && in_ready;
    end else begin : g_body
      assign stg_a[k] = a_r[k-1];
      assign stg_b[k] = b_r[k-1];
      assign stg_s[k] = s_r[k-1];
      assign stg_c[k] = c_r[k-1];
      assign stg_v[k] = v_r[k-1];
    end

    assign seg_res[k] = {1'b0, stg_a[k][LO +: SEG]}
                      + {1'b0, stg_b[k][LO +: SEG]}
                      + {{SEG{1'b0}}, stg_c[k]};

    // Merge this stage's segment into the partial result carried from below.
    always_comb begin
      s_next             = stg_s[k];
      s_next[LO +: SEG]  = seg_res[k][SEG-1:0];
    end

    // Stage register: valid moves with every advance; data loads only for real ops so the
    // output holds its last value across bubbles.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= stg_v[k];
        if (stg_v[k]) begin
          c_q <= seg_res[k][SEG];
          s_q <= s_next;
        end
      end
    end

    assign s_r[k] = s_q;
    assign c_r[k] = c_q;
    assign v_r[k] = v_q;

    if (k < LAST) begin : g_skew
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      // Skew registers carry the not-yet-added operand segments to the next stage.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en && stg_v[k]) begin
          a_q <= stg_a[k];
          b_q <= stg_b[k];
        end
      end

      assign a_r[k] = a_q;
      assign b_r[k] = b_q;
    end else begin : g_no_skew
      assign a_r[k] = '0;
      assign b_r[k] = '0;
    end
  end

  // Carry into the MSB recovered from the MSB's own sum bit: s = a ^ b ^ c_in.
  assign msb_carry = stg_a[LAST][WIDTH-1] ^ stg_b[LAST][WIDTH-1] ^ seg_res[LAST][SEG-1];

  // Overflow flag registered alongside the last stage's result.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (en && stg_v[LAST]) begin
      ovf_q <= msb_carry ^ seg_res[LAST][SEG];
    end
  end

  assign out_valid = v_r[LAST];
  assign sum       = s_r[LAST];
  assign cout      = c_r[LAST];
  assign ovf       = ovf_q;

  // Lower operand bits are consumed by earlier stages; the tail skew slot is constant.
  logic unused_bits;
  assign unused_bits = ^{stg_a, stg_b, a_r[LAST], b_r[LAST]};

endmodule
